// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types; instruction-cache frame, state and sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;

    // Tag field is sized for the widest legal tag so the struct is
    // independent of the SETS override; unused upper bits stay zero.
    localparam int ICACHE_TAG_FIELD_W = 30;

    typedef struct packed {
        logic                          valid;
        logic [ICACHE_TAG_FIELD_W-1:0] tag;
        logic [31:0]                   data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } icachestate_t;

endpackage

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped read-only instruction cache, one-word fills.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_dm
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        inv,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_W = 30 - IDX_W;

    icachestate_t  state;
    icachestate_t  next_state;
    icache_frame_t frames [SETS];
    logic [29:0]   miss_addr;

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] miss_index;
    logic [TAG_W-1:0] miss_tag;
    logic [1:0]       unused_addr_lsb;
    logic             tag_match;
    logic             lookup;
    logic             miss;
    logic             fill_done;

    assign index           = imemaddr[IDX_W+1:2];
    assign tag             = imemaddr[31:IDX_W+2];
    assign unused_addr_lsb = imemaddr[1:0];
    assign miss_index      = miss_addr[IDX_W-1:0];
    assign miss_tag        = miss_addr[29:IDX_W];

    assign tag_match = frames[index].valid &&
                       (frames[index].tag == ICACHE_TAG_FIELD_W'(tag));
    // inv masks the lookup entirely: no hit and no miss that cycle
    assign lookup    = (state == IC_IDLE) && imemREN && !inv;
    assign miss      = lookup && !tag_match;
    assign fill_done = (state == IC_FETCH) && !iwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'd0;
        iREN       = 1'b0;
        iaddr      = 32'd0;
        case (state)
            IC_IDLE: begin
                if (lookup && tag_match) begin
                    ihit     = 1'b1;
                    imemload = frames[index].data;
                end
                if (miss) begin
                    next_state = IC_FETCH;
                end
            end
            IC_FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
                if (inv || !iwait) begin
                    next_state = IC_IDLE;
                end
            end
            default: next_state = IC_IDLE;
        endcase
    end

    // Invalidate outranks a completing fill so the frame stays invalid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else if (inv) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else if (fill_done) begin
            frames[miss_index] <= '{valid: 1'b1,
                                    tag:   ICACHE_TAG_FIELD_W'(miss_tag),
                                    data:  iload};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_addr  <= 30'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (miss) begin
                miss_addr  <= {tag, index};
                miss_count <= miss_count + 32'd1;
            end
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ============================================================================
// Module      : tb_icache_dm
// Description : Directed self-checking bench for icache_dm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_dm;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        inv;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int tests  = 0;
    int failed = 0;

    icache_dm dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .inv        (inv),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; inv = 1'b0;
        iwait = 1'b1; iload = 32'd0;
        cyc();
        cyc();
        RST = 1'b0;
        #1;
    endtask

    // Miss then complete the fill in the first FETCH cycle; ends in IDLE, imemREN=0
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iload = d;
        cyc();
        imemREN = 1'b0;
        cyc();
        iwait = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; inv = 1'b0;
        iwait = 1'b1; iload = 32'd0;
        #1;
        tests++; if (ihit !== 1'b0 || imemload !== 32'd0) begin failed++; $display("FAIL reset_hit ihit=%0b imemload=%h exp 0/0", ihit, imemload); end
        tests++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin failed++; $display("FAIL reset_mem iREN=%0b iaddr=%h exp 0/0", iREN, iaddr); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin failed++; $display("FAIL reset_cnt hit=%0d miss=%0d exp 0/0", hit_count, miss_count); end
        cyc();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h0000_0040; iwait = 1'b1;
        #1;
        tests++; if (ihit !== 1'b0 || iREN !== 1'b0) begin failed++; $display("FAIL cold_detect ihit=%0b iREN=%0b exp 0/0", ihit, iREN); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin iwait = 1'b0; iload = 32'h2001_0005; end
            #1;
            tests++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin failed++; $display("FAIL cold_fetch%0d iREN=%0b iaddr=%h exp 1/00000040", i, iREN, iaddr); end
            cyc();
        end
        iwait = 1'b1;
        #1;
        tests++; if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin failed++; $display("FAIL cold_hit ihit=%0b imemload=%h exp 1/20010005", ihit, imemload); end
        tests++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin failed++; $display("FAIL cold_cnt miss=%0d hit=%0d exp 1/0", miss_count, hit_count); end
        cyc();
        imemREN = 1'b0;
        #1;
        tests++; if (hit_count !== 32'd1 || iREN !== 1'b0) begin failed++; $display("FAIL cold_hitcnt hit=%0d iREN=%0b exp 1/0", hit_count, iREN); end
    endtask

    task automatic test_hit_stream();
        logic [31:0] data [3];
        data[0] = 32'h1111_0000; data[1] = 32'h2222_0004; data[2] = 32'h3333_0008;
        do_reset();
        for (int i = 0; i < 3; i++) fill(32'(i * 4), data[i]);
        tests++; if (miss_count !== 32'd3 || hit_count !== 32'd0) begin failed++; $display("FAIL stream_fills miss=%0d hit=%0d exp 3/0", miss_count, hit_count); end
        for (int i = 0; i < 3; i++) begin
            imemREN = 1'b1; imemaddr = 32'(i * 4);
            #1;
            tests++; if (ihit !== 1'b1 || imemload !== data[i] || iREN !== 1'b0) begin failed++; $display("FAIL stream_hit%0d ihit=%0b load=%h iREN=%0b exp 1/%h/0", i, ihit, imemload, iREN, data[i]); end
            cyc();
        end
        imemREN = 1'b0;
        #1;
        tests++; if (hit_count !== 32'd3 || miss_count !== 32'd3) begin failed++; $display("FAIL stream_cnt hit=%0d miss=%0d exp 3/3", hit_count, miss_count); end
    endtask

    task automatic test_conflict();
        do_reset();
        fill(32'h0000_0004, 32'hAAAA_AAAA);
        imemREN = 1'b1; imemaddr = 32'h0000_0044; iwait = 1'b0; iload = 32'h5555_5555;
        #1;
        tests++; if (ihit !== 1'b0) begin failed++; $display("FAIL conflict_miss ihit=%0b exp 0", ihit); end
        cyc();
        tests++; if (iaddr !== 32'h44 || iREN !== 1'b1) begin failed++; $display("FAIL conflict_iaddr iaddr=%h iREN=%0b exp 00000044/1", iaddr, iREN); end
        cyc();
        tests++; if (ihit !== 1'b1 || imemload !== 32'h5555_5555) begin failed++; $display("FAIL conflict_hit ihit=%0b load=%h exp 1/55555555", ihit, imemload); end
        imemaddr = 32'h0000_0004;
        #1;
        tests++; if (ihit !== 1'b0) begin failed++; $display("FAIL conflict_evict ihit=%0b exp 0", ihit); end
        cyc();
        tests++; if (miss_count !== 32'd3 || iaddr !== 32'h04) begin failed++; $display("FAIL conflict_cnt miss=%0d iaddr=%h exp 3/00000004", miss_count, iaddr); end
        imemREN = 1'b0;
        cyc();
        iwait = 1'b1;
    endtask

    task automatic test_addr_change();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        cyc();
        imemaddr = 32'h20;
        #1;
        tests++; if (iaddr !== 32'h10 || iREN !== 1'b1 || ihit !== 1'b0) begin failed++; $display("FAIL chg_hold iaddr=%h iREN=%0b ihit=%0b exp 00000010/1/0", iaddr, iREN, ihit); end
        cyc();
        iwait = 1'b0; iload = 32'h0000_1111;
        #1;
        tests++; if (iaddr !== 32'h10) begin failed++; $display("FAIL chg_fill iaddr=%h exp 00000010", iaddr); end
        cyc();
        iload = 32'h0000_2222;
        tests++; if (ihit !== 1'b0 || iREN !== 1'b0) begin failed++; $display("FAIL chg_newmiss ihit=%0b iREN=%0b exp 0/0", ihit, iREN); end
        cyc();
        tests++; if (iaddr !== 32'h20 || miss_count !== 32'd2) begin failed++; $display("FAIL chg_iaddr iaddr=%h miss=%0d exp 00000020/2", iaddr, miss_count); end
        cyc();
        tests++; if (ihit !== 1'b1 || imemload !== 32'h0000_2222) begin failed++; $display("FAIL chg_hit20 ihit=%0b load=%h exp 1/00002222", ihit, imemload); end
        imemaddr = 32'h10;
        #1;
        tests++; if (ihit !== 1'b1 || imemload !== 32'h0000_1111) begin failed++; $display("FAIL chg_hit10 ihit=%0b load=%h exp 1/00001111", ihit, imemload); end
        imemREN = 1'b0; iwait = 1'b1;
        cyc();
    endtask

    task automatic test_inv();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1;
        cyc();
        iwait = 1'b0; iload = 32'h0000_3333; inv = 1'b1;
        cyc();
        inv = 1'b0; iwait = 1'b1;
        #1;
        tests++; if (iREN !== 1'b0 || ihit !== 1'b0) begin failed++; $display("FAIL inv_fill iREN=%0b ihit=%0b exp 0/0", iREN, ihit); end
        cyc();
        tests++; if (iREN !== 1'b1 || miss_count !== 32'd2) begin failed++; $display("FAIL inv_remiss iREN=%0b miss=%0d exp 1/2", iREN, miss_count); end
        iwait = 1'b0;
        cyc();
        iwait = 1'b1;
        tests++; if (ihit !== 1'b1 || imemload !== 32'h0000_3333) begin failed++; $display("FAIL inv_refill ihit=%0b load=%h exp 1/00003333", ihit, imemload); end
        inv = 1'b1;
        #1;
        tests++; if (ihit !== 1'b0 || imemload !== 32'd0) begin failed++; $display("FAIL inv_mask ihit=%0b load=%h exp 0/0", ihit, imemload); end
        cyc();
        inv = 1'b0;
        #1;
        tests++; if (miss_count !== 32'd2 || ihit !== 1'b0 || iREN !== 1'b0) begin failed++; $display("FAIL inv_nomiss miss=%0d ihit=%0b iREN=%0b exp 2/0/0", miss_count, ihit, iREN); end
        cyc();
        tests++; if (miss_count !== 32'd3 || iREN !== 1'b1) begin failed++; $display("FAIL inv_after miss=%0d iREN=%0b exp 3/1", miss_count, iREN); end
        inv = 1'b1; imemREN = 1'b0;
        cyc();
        inv = 1'b0;
        #1;
        tests++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin failed++; $display("FAIL inv_abort iREN=%0b iaddr=%h exp 0/0", iREN, iaddr); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        fill(32'h08, 32'h0000_0808);
        imemREN = 1'b1; imemaddr = 32'h08;
        #1;
        tests++; if (ihit !== 1'b1) begin failed++; $display("FAIL rmf_prehit ihit=%0b exp 1", ihit); end
        cyc();
        imemaddr = 32'h50; iwait = 1'b1;
        cyc();
        RST = 1'b1;
        #1;
        tests++; if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'd0) begin failed++; $display("FAIL rmf_out iREN=%0b ihit=%0b iaddr=%h exp 0/0/0", iREN, ihit, iaddr); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin failed++; $display("FAIL rmf_cnt hit=%0d miss=%0d exp 0/0", hit_count, miss_count); end
        iwait = 1'b0;
        cyc();
        RST = 1'b0; imemaddr = 32'h08;
        #1;
        tests++; if (ihit !== 1'b0) begin failed++; $display("FAIL rmf_cold ihit=%0b exp 0", ihit); end
        cyc();
        tests++; if (iREN !== 1'b1 || iaddr !== 32'h08 || miss_count !== 32'd1) begin failed++; $display("FAIL rmf_refetch iREN=%0b iaddr=%h miss=%0d exp 1/00000008/1", iREN, iaddr, miss_count); end
        imemREN = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_addr_change();
        test_inv();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
